// File: rtl/traffic_light_multi_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
//   Shared types and helpers for the multi-direction traffic-light controller.
//   - state_t   : controller phase
//   - lamp_t    : lamp set of one approach direction {red, yellow, green}
//   - MAX_DIR   : largest supported number of approach directions
//   - phase_dur : duration in seconds of a phase (a 0 duration counts as 1)
//   - lamp_for  : lamp set of one direction in a given phase
// ----------------------------------------------------------------------------
package traffic_pkg;

   localparam int unsigned MAX_DIR = 4;

   typedef enum logic [2:0] {
      ALL_RED,
      RED_YELLOW,
      GREEN,
      YELLOW,
      PED_WALK,
      BLINK
   } state_t;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   function automatic int unsigned at_least_one(input int unsigned d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned phase_dur(input state_t s,
                                             input int unsigned green_s,
                                             input int unsigned yellow_s,
                                             input int unsigned red_yellow_s,
                                             input int unsigned all_red_s,
                                             input int unsigned ped_s);
      case (s)
         RED_YELLOW: return at_least_one(red_yellow_s);
         GREEN:      return at_least_one(green_s);
         YELLOW:     return at_least_one(yellow_s);
         PED_WALK:   return at_least_one(ped_s);
         default:    return at_least_one(all_red_s);
      endcase
   endfunction

   // Only the served direction ever leaves red; BLINK drives yellow alone.
   function automatic lamp_t lamp_for(input state_t s, input logic served,
                                      input logic blink_on);
      case (s)
         RED_YELLOW: return served ? lamp_t'{1'b1, 1'b1, 1'b0} : lamp_t'{1'b1, 1'b0, 1'b0};
         GREEN:      return served ? lamp_t'{1'b0, 1'b0, 1'b1} : lamp_t'{1'b1, 1'b0, 1'b0};
         YELLOW:     return served ? lamp_t'{1'b0, 1'b1, 1'b0} : lamp_t'{1'b1, 1'b0, 1'b0};
         BLINK:      return lamp_t'{1'b0, blink_on, 1'b0};
         default:    return lamp_t'{1'b1, 1'b0, 1'b0};
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_multi_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to a one-cycle pulse per second.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : count enable; 0 freezes the count
//   sec_tick   : high in the cycle the count sits at CLK_FREQ-1 (while enabled)
// ----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int unsigned CLK_FREQ = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   output logic sec_tick
);

   localparam int unsigned   CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] TC = CW'(CLK_FREQ - 1);

   logic [CW-1:0] count;

   // Gated by ena so a frozen count parked at TC does not emit a stuck pulse.
   assign sec_tick = ena && (count == TC);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the simulator runs blocks in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (ena)
         count <= (count == TC) ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/traffic_light_multi.sv
// ----------------------------------------------------------------------------
// traffic_light_multi
//   Round-robin traffic-light controller for NUM_DIR approach directions with
//   a latched pedestrian all-walk phase.
//   Optional: define TRAFFIC_NIGHT_BLINK_EN to enable the night flashing-yellow
//   mode driven by the night input; without it night is ignored.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     ena                 : run enable; 0 freezes prescaler, timer and FSM
//     ped_btn             : pedestrian button (asynchronous level)
//     night               : night-mode request (asynchronous level)
//     red/yellow/green    : lamps, one bit per direction
//     ped_walk, ped_wait  : walk lamp, request-pending indicator
//     dir_idx             : currently served direction
//     sec_tick            : one-cycle pulse per second
// ----------------------------------------------------------------------------
module traffic_light_multi
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 1_000_000,
   parameter int unsigned NUM_DIR      = 2,
   parameter int unsigned GREEN_S      = 10,
   parameter int unsigned YELLOW_S     = 3,
   parameter int unsigned RED_YELLOW_S = 1,
   parameter int unsigned ALL_RED_S    = 1,
   parameter int unsigned PED_S        = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic                       ped_btn,
   input  logic                       night,
   output logic [NUM_DIR-1:0]         red,
   output logic [NUM_DIR-1:0]         yellow,
   output logic [NUM_DIR-1:0]         green,
   output logic                       ped_walk,
   output logic                       ped_wait,
   output logic [$clog2(NUM_DIR)-1:0] dir_idx,
   output logic                       sec_tick
);

   localparam int unsigned DIR_W   = $clog2(NUM_DIR);
   localparam int unsigned MAX_DUR = max_u(max_u(max_u(at_least_one(GREEN_S), at_least_one(YELLOW_S)),
                                                 max_u(at_least_one(RED_YELLOW_S), at_least_one(ALL_RED_S))),
                                           at_least_one(PED_S));
   localparam int unsigned TW      = $clog2(MAX_DUR + 1);

   typedef lamp_t [NUM_DIR-1:0] lamp_vec_t;

   function automatic lamp_vec_t lamps(input state_t s, input logic [DIR_W-1:0] d,
                                       input logic blink_on);
      lamp_vec_t v;
      for (int i = 0; i < NUM_DIR; i++)
         v[i] = lamp_for(s, d == DIR_W'(i), blink_on);
      return v;
   endfunction

   state_t           state;
   lamp_vec_t        lamp_q;
   logic             ped_walk_q;
   logic [DIR_W-1:0] dir_idx_q;
   logic [DIR_W-1:0] next_dir;
   logic             first_q;     // next vehicle phase serves dir 0 without advancing
   logic [TW-1:0]    timer;
   logic             phase_end;
   logic [2:0]       ped_sync;    // [1:0] synchroniser, [2] edge-detect history
   logic             ped_rise;
   logic             ped_pending;
   logic             enter_ped;
   logic             night_req;

   tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .sec_tick (sec_tick)
   );

`ifdef TRAFFIC_NIGHT_BLINK_EN
   logic [1:0] night_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         night_sync <= '0;
      else
         night_sync <= {night_sync[0], night};
   end

   assign night_req = night_sync[1];
`else
   logic unused_night;

   assign unused_night = night;
   assign night_req    = 1'b0;
`endif

   // Synchroniser runs regardless of ena so presses while frozen are kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ped_sync <= '0;
      else
         ped_sync <= {ped_sync[1:0], ped_btn};
   end

   assign ped_rise  = ped_sync[1] & ~ped_sync[2];
   assign phase_end = sec_tick &&
                      (timer == TW'(phase_dur(state, GREEN_S, YELLOW_S, RED_YELLOW_S,
                                              ALL_RED_S, PED_S) - 1));
   assign enter_ped = ena && !night_req && (state == ALL_RED) && phase_end && ped_pending;

   // A new press wins over the clear caused by entering the walk phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ped_pending <= 1'b0;
      else if (ped_rise)
         ped_pending <= 1'b1;
      else if (enter_ped)
         ped_pending <= 1'b0;
   end

   // NOTE: every path assigns next_dir, so this stays combinational (no latch).
   always_comb begin
      next_dir = '0;
      if (!first_q && (dir_idx_q != DIR_W'(NUM_DIR - 1)))
         next_dir = dir_idx_q + 1'b1;
   end

   // Lamps are registered together with the state so they change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ALL_RED;
         dir_idx_q  <= '0;
         first_q    <= 1'b1;
         timer      <= '0;
         lamp_q     <= lamps(ALL_RED, '0, 1'b0);
         ped_walk_q <= 1'b0;
      end else if (ena) begin
         if (night_req && (state != BLINK)) begin
            state      <= BLINK;
            timer      <= '0;
            lamp_q     <= lamps(BLINK, dir_idx_q, 1'b1);
            ped_walk_q <= 1'b0;
         end else if (state == BLINK) begin
            if (!night_req) begin
               // Leaving night mode restarts the rotation like a fresh reset.
               state     <= ALL_RED;
               timer     <= '0;
               dir_idx_q <= '0;
               first_q   <= 1'b1;
               lamp_q    <= lamps(ALL_RED, '0, 1'b0);
            end else if (sec_tick) begin
               lamp_q <= lamps(BLINK, dir_idx_q, ~lamp_q[0].yellow);
            end
         end else if (phase_end) begin
            timer <= '0;
            case (state)
               ALL_RED: begin
                  if (ped_pending) begin
                     state      <= PED_WALK;
                     lamp_q     <= lamps(PED_WALK, dir_idx_q, 1'b0);
                     ped_walk_q <= 1'b1;
                  end else begin
                     state     <= RED_YELLOW;
                     dir_idx_q <= next_dir;
                     first_q   <= 1'b0;
                     lamp_q    <= lamps(RED_YELLOW, next_dir, 1'b0);
                  end
               end
               RED_YELLOW: begin
                  state  <= GREEN;
                  lamp_q <= lamps(GREEN, dir_idx_q, 1'b0);
               end
               GREEN: begin
                  state  <= YELLOW;
                  lamp_q <= lamps(YELLOW, dir_idx_q, 1'b0);
               end
               default: begin
                  // YELLOW and PED_WALK both clear to ALL_RED.
                  state      <= ALL_RED;
                  lamp_q     <= lamps(ALL_RED, dir_idx_q, 1'b0);
                  ped_walk_q <= 1'b0;
               end
            endcase
         end else if (sec_tick) begin
            timer <= timer + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
      assign red[i]    = lamp_q[i].red;
      assign yellow[i] = lamp_q[i].yellow;
      assign green[i]  = lamp_q[i].green;
   end

   assign ped_walk = ped_walk_q;
   assign ped_wait = ped_pending;
   assign dir_idx  = dir_idx_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_multi
//   Self-checking bench for traffic_light_multi (CLK_FREQ=4, NUM_DIR=3).
//   A table of expected lamp phases covers the first rotation; hand-written
//   sequences cover pedestrian, freeze, async reset and night mode; a random
//   run is compared every cycle against a seconds-countdown reference model.
// ----------------------------------------------------------------------------
module tb_traffic_light_multi;

   localparam int CLK_FREQ = 4;
   localparam int NUM_DIR  = 3;
   localparam int GREEN_S  = 2;
   localparam int YELLOW_S = 1;
   localparam int RY_S     = 1;
   localparam int AR_S     = 1;
   localparam int PED_S    = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       ped_btn = 1'b0;
   logic       night = 1'b0;
   logic [2:0] red, yellow, green;
   logic       ped_walk, ped_wait, sec_tick;
   logic [1:0] dir_idx;

   int n_tests = 0;
   int n_fail  = 0;

   traffic_light_multi #(
      .CLK_FREQ(CLK_FREQ), .NUM_DIR(NUM_DIR), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S),
      .RED_YELLOW_S(RY_S), .ALL_RED_S(AR_S), .PED_S(PED_S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ped_btn(ped_btn), .night(night),
      .red(red), .yellow(yellow), .green(green), .ped_walk(ped_walk),
      .ped_wait(ped_wait), .dir_idx(dir_idx), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: phases counted down in whole seconds
   typedef enum int {M_AR, M_RY, M_G, M_Y, M_PED, M_BLINK} mphase_t;

   mphase_t  m_ph;
   int       m_dir, m_left, m_pres;
   bit       m_first, m_pend, m_blink_y;
   bit [2:0] m_bh;   // button samples, newest in bit 0
   bit [1:0] m_nh;   // night samples, newest in bit 0

   function automatic int dur_of(input mphase_t p);
      int d;
      case (p)
         M_RY:    d = RY_S;
         M_G:     d = GREEN_S;
         M_Y:     d = YELLOW_S;
         M_PED:   d = PED_S;
         default: d = AR_S;
      endcase
      return (d == 0) ? 1 : d;
   endfunction

   task automatic model_reset();
      m_ph = M_AR; m_dir = 0; m_first = 1; m_left = dur_of(M_AR); m_pres = 0;
      m_pend = 0; m_blink_y = 0; m_bh = '0; m_nh = '0;
   endtask

   task automatic model_edge();
      bit rise, nreq, enter_ped, tick;
      rise = m_bh[1] && !m_bh[2];
`ifdef TRAFFIC_NIGHT_BLINK_EN
      nreq = m_nh[1];
      m_nh = {m_nh[0], night};
`else
      nreq = 0;
`endif
      m_bh = {m_bh[1:0], ped_btn};
      enter_ped = 0;
      if (ena) begin
         tick   = (m_pres == CLK_FREQ - 1);
         m_pres = (m_pres + 1) % CLK_FREQ;
         if (nreq && m_ph != M_BLINK) begin
            m_ph = M_BLINK; m_blink_y = 1;
         end else if (m_ph == M_BLINK) begin
            if (!nreq) begin
               m_ph = M_AR; m_left = dur_of(M_AR); m_dir = 0; m_first = 1;
            end else if (tick) m_blink_y = !m_blink_y;
         end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
               case (m_ph)
                  M_AR: if (m_pend) begin
                     m_ph = M_PED; enter_ped = 1;
                  end else begin
                     if (!m_first) m_dir = (m_dir + 1) % NUM_DIR;
                     m_first = 0; m_ph = M_RY;
                  end
                  M_RY:    m_ph = M_G;
                  M_G:     m_ph = M_Y;
                  default: m_ph = M_AR;
               endcase
               m_left = dur_of(m_ph);
            end
         end
      end
      m_pend = (m_pend && !enter_ped) || rise;
   endtask

   task automatic compare_model();
      logic [2:0] er, ey, eg;
      for (int i = 0; i < NUM_DIR; i++) begin
         bit served;
         served = (i == m_dir);
         er[i] = (m_ph == M_BLINK) ? 1'b0 : !(served && (m_ph == M_G || m_ph == M_Y));
         ey[i] = (m_ph == M_BLINK) ? m_blink_y : (served && (m_ph == M_RY || m_ph == M_Y));
         eg[i] = served && (m_ph == M_G);
      end
      check("red", red, er);
      check("yellow", yellow, ey);
      check("green", green, eg);
      check("ped_walk", ped_walk, m_ph == M_PED);
      check("ped_wait", ped_wait, m_pend);
      check("dir_idx", dir_idx, m_dir);
      check("sec_tick", sec_tick, ena && (m_pres == CLK_FREQ - 1));
      if (m_ph != M_BLINK) check("one_dir_active", $countones(green | yellow) <= 1, 1);
      check("green_walk_excl", (|green) && ped_walk, 0);
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_edge();
      @(negedge clk);
      compare_model();
   endtask

   task automatic do_reset();
      rst_n = 0; ena = 1; ped_btn = 0; night = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      model_reset();
      compare_model();
   endtask

   // ---------------- first-rotation table
   typedef struct {
      int       n;
      bit [2:0] r, y, g;
      bit       w;
      int       d;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int cyc, n, changes;
      bit seen;
      logic [2:0] sr, sy, sg, prev_y;
      logic [1:0] sd;

      tbl[0]  = '{3, 3'b111, 3'b000, 3'b000, 1'b0, 0};
      tbl[1]  = '{4, 3'b111, 3'b001, 3'b000, 1'b0, 0};
      tbl[2]  = '{8, 3'b110, 3'b000, 3'b001, 1'b0, 0};
      tbl[3]  = '{4, 3'b110, 3'b001, 3'b000, 1'b0, 0};
      tbl[4]  = '{4, 3'b111, 3'b000, 3'b000, 1'b0, 0};
      tbl[5]  = '{4, 3'b111, 3'b010, 3'b000, 1'b0, 1};
      tbl[6]  = '{8, 3'b101, 3'b000, 3'b010, 1'b0, 1};
      tbl[7]  = '{4, 3'b101, 3'b010, 3'b000, 1'b0, 1};
      tbl[8]  = '{4, 3'b111, 3'b000, 3'b000, 1'b0, 1};
      tbl[9]  = '{4, 3'b111, 3'b100, 3'b000, 1'b0, 2};
      tbl[10] = '{8, 3'b011, 3'b000, 3'b100, 1'b0, 2};
      tbl[11] = '{4, 3'b011, 3'b100, 3'b000, 1'b0, 2};
      tbl[12] = '{4, 3'b111, 3'b000, 3'b000, 1'b0, 2};
      tbl[13] = '{4, 3'b111, 3'b001, 3'b000, 1'b0, 0};

      // Reset state and first rotation (dir 0,1,2,0), sec_tick every 4 clocks.
      do_reset();
      check("rst_red", red, 3'b111);
      check("rst_yellow_green", {yellow, green}, 6'b0);
      check("rst_dir", dir_idx, 0);
      cyc = 0;
      for (int e = 0; e < 14; e++) begin
         for (int k = 0; k < tbl[e].n; k++) begin
            step();
            cyc++;
            check("tbl_red", red, tbl[e].r);
            check("tbl_yellow", yellow, tbl[e].y);
            check("tbl_green", green, tbl[e].g);
            check("tbl_walk", ped_walk, tbl[e].w);
            check("tbl_dir", dir_idx, tbl[e].d);
            check("tbl_tick", sec_tick, (cyc % 4) == 3);
         end
      end

      // Pedestrian press during dir 1 green.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         if (dir_idx == 1 && green == 3'b010) break;
         step();
      end
      check("ped_reach_g1", green, 3'b010);
      ped_btn = 1; seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         ped_btn = 0;
         if (ped_wait) seen = 1;
      end
      check("ped_wait_set", seen, 1);
      for (int i = 0; i < 100; i++) begin
         if (ped_walk) break;
         step();
      end
      check("ped_walk_start", ped_walk, 1);
      check("ped_walk_dir", dir_idx, 1);
      n = 0;
      while (ped_walk && n < 50) begin
         n++;
         step();
      end
      check("ped_walk_len", n, 8);
      check("ped_wait_clear", ped_wait, 0);
      for (int i = 0; i < 50; i++) begin
         if (yellow != 0) break;
         step();
      end
      check("ped_next_dir", dir_idx, 2);
      check("ped_next_ry", yellow, 3'b100);

      // Freeze mid-green for 20 cycles, then green time resumes exactly.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (green != 0) break;
         step();
      end
      check("frz_green", green, 3'b001);
      for (int i = 0; i < 3; i++) step();
      sr = red; sy = yellow; sg = green; sd = dir_idx;
      ena = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         check("frz_hold", {red, yellow, green, dir_idx, ped_walk}, {sr, sy, sg, sd, 1'b0});
      end
      ena = 1; n = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (green == 0) break;
         n++;
      end
      check("frz_resume_len", n, 4);
      check("frz_then_yellow", yellow, 3'b001);

      // Asynchronous reset mid-yellow with a pending request.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (green != 0) break;
         step();
      end
      ped_btn = 1; step(); ped_btn = 0;
      for (int i = 0; i < 100; i++) begin
         if (yellow == 3'b001 && red == 3'b110) break;
         step();
      end
      check("ar_in_yellow", yellow, 3'b001);
      check("ar_pending", ped_wait, 1);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      check("ar_red", red, 3'b111);
      check("ar_yg", {yellow, green}, 6'b0);
      check("ar_ped_wait", ped_wait, 0);
      check("ar_dir", dir_idx, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      compare_model();
      for (int i = 0; i < 10; i++) step();

`ifdef TRAFFIC_NIGHT_BLINK_EN
      // Night mode from green: blink, then restart at dir 0.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (green != 0) break;
         step();
      end
      night = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (yellow == 3'b111 && red == 0) break;
      end
      check("nt_blink_on", {red, yellow, green}, {3'b000, 3'b111, 3'b000});
      changes = 0; prev_y = yellow;
      for (int i = 0; i < 16; i++) begin
         step();
         if (yellow != prev_y) changes++;
         prev_y = yellow;
         check("nt_yellow_uniform", (yellow == 3'b111) || (yellow == 3'b000), 1);
      end
      check("nt_toggles", changes, 4);
      night = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (red == 3'b111) break;
      end
      check("nt_exit_allred", {red, yellow, green}, {3'b111, 3'b000, 3'b000});
      for (int i = 0; i < 20; i++) begin
         if (yellow != 0) break;
         step();
      end
      check("nt_first_dir", dir_idx, 0);
      check("nt_first_ry", yellow, 3'b001);
`endif

      // Random run against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ena = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) ped_btn = ~ped_btn;
`ifdef TRAFFIC_NIGHT_BLINK_EN
         if ($urandom_range(0, 149) == 0) night = ~night;
`endif
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
- Parametrised successor of the single-junction traffic-light controller.
- Sequences N approach directions through a round-robin light cycle, with configurable per-phase durations in seconds.
- Adds a latched pedestrian all-walk phase, and an optional night flashing-yellow mode.
- Instantiated inside the TinyTapeout top wrapper; lamp outputs map to uo_out/uio_out.

Parameters:
CLK_FREQ, 1_000_000, input clock in Hz; prescaler terminal count = CLK_FREQ-1 (sim builds use a small value)
NUM_DIR, 2, number of approach directions, legal 2..4
GREEN_S, 10, green duration in seconds
YELLOW_S, 3, yellow duration in seconds
RED_YELLOW_S, 1, red+yellow duration in seconds
ALL_RED_S, 1, all-red clearance in seconds
PED_S, 8, pedestrian walk duration in seconds

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  run enable; 0 freezes prescaler, timer and FSM
ped_btn  input  1  pedestrian button, asynchronous, level
night  input  1  night-mode request, asynchronous, level (used only with NIGHT_BLINK_EN)
red  output  NUM_DIR  red lamp per direction
yellow  output  NUM_DIR  yellow lamp per direction
green  output  NUM_DIR  green lamp per direction
ped_walk  output  1  pedestrian walk lamp
ped_wait  output  1  request pending indicator (= ped_pending)
dir_idx  output  $clog2(NUM_DIR)  currently served direction
sec_tick  output  1  one-cycle pulse once per second

Behaviour:
- Reset values:
  - state ALL_RED, dir_idx 0, red all 1, yellow/green 0, ped_walk 0, ped_pending 0, prescaler 0, seconds timer 0.
  - All flops reset asynchronously on rst_n low; release is synchronous to clk.
- Prescaler:
  - Counts 0..CLK_FREQ-1 while ena=1.
  - sec_tick=1 in the cycle the count equals CLK_FREQ-1, then the count wraps to 0.
- Seconds timer:
  - Width $clog2(max duration + 1).
  - Increments on sec_tick; clears on every state change.
  - A phase ends on the sec_tick where timer == DUR-1. A DUR of 0 is treated as 1.
- State changes occur in the cycle after that sec_tick; outputs are registered and follow the state.
- States and transitions:
  - ALL_RED:
    - if ped_pending -> PED_WALK
    - else -> RED_YELLOW, with dir_idx advanced (wrap NUM_DIR-1 -> 0)
    - Exception: the first ALL_RED after reset serves dir 0 without advancing.
  - RED_YELLOW -> GREEN -> YELLOW -> ALL_RED.
  - PED_WALK -> ALL_RED. dir_idx is unchanged, so the next vehicle phase serves dir_idx+1.
- Lamp mapping:
  - The served direction shows red+yellow, green, or yellow in the three vehicle phases.
  - Every unserved direction shows red only.
  - ALL_RED and PED_WALK: all red.
  - ped_walk=1 only in PED_WALK.
- Pedestrian request:
  - ped_btn passes through a 2-FF synchroniser; a rising edge sets ped_pending.
  - ped_pending clears in the cycle PED_WALK is entered.
  - A press during PED_WALK sets it again, giving another walk phase after the next ALL_RED.
  - A press with ena=0 is still latched.
- Simultaneous events: a set and a clear of ped_pending in the same cycle resolve to set.
- ena=0: all counters and the FSM hold; outputs hold their last values.
- Safety invariant: at most one direction has green or yellow at any time; green and ped_walk are never both 1.

Optional Feature:
TRAFFIC_NIGHT_BLINK_EN
- Defined:
  - The synchronised night=1 forces the BLINK state from any state on the next cycle.
  - In BLINK: red and green are all 0, ped_walk is 0, and all yellow bits toggle on each sec_tick, starting at 1 on entry.
  - night=0 exits to ALL_RED with the timer cleared and dir_idx reset to 0, treated like the post-reset entry (dir 0 served first).
  - ped_pending is retained across BLINK.
- Undefined: the night port is ignored, BLINK is unreachable, and no synchroniser flops are generated for it.

Decomposition:
- Package traffic_pkg holds:
  - the state enum (ALL_RED, RED_YELLOW, GREEN, YELLOW, PED_WALK, BLINK)
  - a lamp-set struct {red, yellow, green}
  - the MAX_DIR=4 constant
  - a function returning the duration for a given state.
- One sub-module: tick_prescaler (CLK_FREQ parameter; ports clk, rst_n, ena, sec_tick).
- The synchronisers stay inline.

Test Plan:
All scenarios use CLK_FREQ=4, NUM_DIR=3, GREEN_S=2, YELLOW_S=1, RED_YELLOW_S=1, ALL_RED_S=1, PED_S=2.
- Reset and first phase: release reset with ena=1 -> red=3'b111 for 4 cycles, then dir 0 shows red+yellow for 4 cycles, green for 8, yellow for 4.
- Round robin: run 3 full cycles -> dir_idx sequence 0,1,2,0; never two green bits set; sec_tick period exactly 4 clocks.
- Pedestrian: pulse ped_btn during dir 1 green -> ped_wait=1 within 3 cycles; after dir 1's ALL_RED, ped_walk=1 for 8 cycles; next vehicle phase is dir 2; ped_wait returns to 0.
- Freeze: drop ena for 20 cycles mid-GREEN -> all outputs and phase progress unchanged; the remaining green time resumes exactly.
- Async reset mid-YELLOW: assert rst_n low between clock edges -> outputs go to all-red immediately, without waiting for a clock edge; ped_pending=0.
- Night mode (macro defined): night=1 during GREEN -> BLINK with yellow=3'b111 / 3'b000 alternating every 4 cycles; night=0 -> ALL_RED, then dir 0 serves first.
